// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: op codes,
// FSM states, counter width and default unit latencies.
package muldiv_pkg;

    localparam int CNT_W        = 6;
    localparam int DEF_DIV_LAT  = 34;
    localparam int DEF_MULT_LAT = 33;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down counter that times the fixed latency of the selected unit.
// o_term flags a count of exactly one, i.e. the final wait cycle.
module muldiv_lat_cnt
    import muldiv_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer for the shared iterative divider/multiplier; owns HI/LO.
// Optional abort input is compiled in when HILO_ABORT_EN is defined.
module hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic        clock,
    input  logic        reset,
`ifdef HILO_ABORT_EN
    input  logic        abort,
`endif
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        div_start,
    output logic        mult_start,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e           r_state;
    logic             r_is_div;
    logic             r_done;
    logic             r_div0;
    logic [31:0]      r_ua;
    logic [31:0]      r_ub;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_abort;
    logic             w_load;
    logic             w_dec;
    logic             w_term;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_lat;

`ifdef HILO_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_lat  = r_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    assign w_load = (r_state == ST_LAUNCH) && !w_abort;
    assign w_dec  = (r_state == ST_WAIT) && (w_cnt != '0);

    muldiv_lat_cnt u_lat_cnt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .i_val   (w_lat),
        .o_cnt   (w_cnt),
        .o_term  (w_term)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_ua     <= '0;
            r_ub     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MTHI: begin
                                r_hi   <= op_a;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= op_a;
                                r_done <= 1'b1;
                            end
                            OP_DIV: begin
                                // Zero divisor is trapped here; the divider never starts.
                                if (op_b == '0) begin
                                    r_div0 <= 1'b1;
                                end else begin
                                    r_ua     <= op_a;
                                    r_ub     <= op_b;
                                    r_is_div <= 1'b1;
                                    r_state  <= ST_LAUNCH;
                                end
                            end
                            default: begin
                                r_ua     <= op_a;
                                r_ub     <= op_b;
                                r_is_div <= 1'b0;
                                r_state  <= ST_LAUNCH;
                            end
                        endcase
                    end
                end
                ST_LAUNCH: r_state <= w_abort ? ST_IDLE : ST_WAIT;
                ST_WAIT: begin
                    if (w_abort)     r_state <= ST_IDLE;
                    else if (w_term) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_hi    <= r_is_div ? div_hi : mult_hi;
                    r_lo    <= r_is_div ? div_lo : mult_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign div_start  = (r_state == ST_LAUNCH) && r_is_div;
    assign mult_start = (r_state == ST_LAUNCH) && !r_is_div;
    assign done       = r_done;
    assign div0_exc   = r_div0;
    assign unit_a     = r_ua;
    assign unit_b     = r_ub;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
